// File: rtl/change_dispenser.sv
// Vending machine output stage: drink-release pulse, or greedy 10/5/1 coin
// refund of change / full credit, finished by a one-clock done pulse.
module change_dispenser #(
  parameter int DRINK_VALUE = 25,
  parameter int MONEY_W     = 8,
  parameter int PULSE_CYC   = 4,
  parameter int GAP_CYC     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         s_state,
  input  logic [MONEY_W-1:0] money_value,
  output logic               drink_out,
  output logic               coin10_out,
  output logic               coin5_out,
  output logic               coin1_out,
  output logic               busy,
  output logic               done,
  output logic [MONEY_W-1:0] change_total
);

  localparam int CNT_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0]   PULSE_LAST = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0]   GAP_LAST   = CNT_W'(GAP_CYC - 1);
  localparam logic [MONEY_W-1:0] PRICE      = MONEY_W'(DRINK_VALUE);

  localparam logic [3:0] ST_EATER   = 4'b0001;
  localparam logic [3:0] ST_DRINK   = 4'b0010;
  localparam logic [3:0] ST_OUT     = 4'b0100;
  localparam logic [3:0] ST_OUT_ALL = 4'b1000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRINK  = 3'd1,
    SELECT = 3'd2,
    PULSE  = 3'd3,
    GAP    = 3'd4,
    DONE   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    COIN_NONE = 2'd0,
    COIN_10   = 2'd1,
    COIN_5    = 2'd2,
    COIN_1    = 2'd3
  } coin_e;

  state_e             state_r, state_next_s;
  coin_e              coin_r, coin_next_s;
  logic [CNT_W-1:0]   cnt_r, cnt_next_s;
  logic [MONEY_W-1:0] remaining_r, remaining_next_s;
  logic [MONEY_W-1:0] total_next_s;
  logic [3:0]         served_r, served_next_s;
  logic               trigger_s;

  // Greedy choice; only called with a non-zero amount.
  function automatic coin_e pick_coin(input logic [MONEY_W-1:0] amt);
    coin_e c;
    if (amt >= MONEY_W'(10)) begin
      c = COIN_10;
    end else if (amt >= MONEY_W'(5)) begin
      c = COIN_5;
    end else begin
      c = COIN_1;
    end
    return c;
  endfunction

  function automatic logic [MONEY_W-1:0] coin_value(input coin_e c);
    logic [MONEY_W-1:0] v;
    case (c)
      COIN_10: v = MONEY_W'(10);
      COIN_5:  v = MONEY_W'(5);
      COIN_1:  v = MONEY_W'(1);
      default: v = '0;
    endcase
    return v;
  endfunction

  // Trigger qualification: a one-hot output state not already serviced.
  always_comb begin
    trigger_s = ((s_state == ST_DRINK) || (s_state == ST_OUT) || (s_state == ST_OUT_ALL))
                && (s_state != served_r);
  end

  // Next-state, counter and datapath update.
  always_comb begin
    state_next_s     = state_r;
    coin_next_s      = coin_r;
    cnt_next_s       = cnt_r;
    remaining_next_s = remaining_r;
    total_next_s     = change_total;
    served_next_s    = served_r;
    case (state_r)
      IDLE: begin
        if (s_state == ST_EATER) begin
          served_next_s = ST_EATER;
        end else if (trigger_s) begin
          served_next_s = s_state;
          total_next_s  = '0;
          cnt_next_s    = '0;
          coin_next_s   = COIN_NONE;
          case (s_state)
            ST_DRINK: begin
              state_next_s = DRINK;
            end
            ST_OUT: begin
              state_next_s     = SELECT;
              remaining_next_s = (money_value >= PRICE) ? (money_value - PRICE) : '0;
            end
            ST_OUT_ALL: begin
              state_next_s     = SELECT;
              remaining_next_s = money_value;
            end
            default: begin
              state_next_s = IDLE;
            end
          endcase
        end else begin
          served_next_s = served_r;
        end
      end
      DRINK: begin
        if (cnt_r == PULSE_LAST) begin
          state_next_s = DONE;
          cnt_next_s   = '0;
        end else begin
          cnt_next_s = cnt_r + CNT_W'(1);
        end
      end
      SELECT: begin
        if (remaining_r == '0) begin
          state_next_s = DONE;
        end else begin
          // Coin is deducted and credited on PULSE entry; greedy keeps it <= remaining.
          coin_next_s      = pick_coin(remaining_r);
          remaining_next_s = remaining_r - coin_value(coin_next_s);
          total_next_s     = change_total + coin_value(coin_next_s);
          cnt_next_s       = '0;
          state_next_s     = PULSE;
        end
      end
      PULSE: begin
        if (cnt_r == PULSE_LAST) begin
          state_next_s = GAP;
          coin_next_s  = COIN_NONE;
          cnt_next_s   = '0;
        end else begin
          cnt_next_s = cnt_r + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_r == GAP_LAST) begin
          state_next_s = SELECT;
          cnt_next_s   = '0;
        end else begin
          cnt_next_s = cnt_r + CNT_W'(1);
        end
      end
      DONE: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
        coin_next_s  = COIN_NONE;
        cnt_next_s   = '0;
      end
    endcase
  end

  // State, datapath and registered outputs, decoded from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      coin_r       <= COIN_NONE;
      cnt_r        <= '0;
      remaining_r  <= '0;
      served_r     <= ST_EATER;
      change_total <= '0;
      drink_out    <= 1'b0;
      coin10_out   <= 1'b0;
      coin5_out    <= 1'b0;
      coin1_out    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      coin_r       <= coin_next_s;
      cnt_r        <= cnt_next_s;
      remaining_r  <= remaining_next_s;
      served_r     <= served_next_s;
      change_total <= total_next_s;
      drink_out    <= (state_next_s == DRINK);
      coin10_out   <= (state_next_s == PULSE) && (coin_next_s == COIN_10);
      coin5_out    <= (state_next_s == PULSE) && (coin_next_s == COIN_5);
      coin1_out    <= (state_next_s == PULSE) && (coin_next_s == COIN_1);
      busy         <= (state_next_s != IDLE);
      done         <= (state_next_s == DONE);
    end
  end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Output stage of the vending machine. It sits directly downstream of the one-hot vending state machine and acts on whichever output state that machine enters. In the drink state it drives the drink-release pulse. In the two money-out states it returns change, or the full credit, as a greedy sequence of 10/5/1 coin-ejector pulses. It emits a one-cycle `done` pulse; the falling edge of `done` is the `flag` that advances the state machine.

## Interface
- `DRINK_VALUE`, 25: drink price in money units.
- `MONEY_W`, 8: width of the credit and change datapath.
- `PULSE_CYC`, 4: high time of each actuator pulse, in clocks (≥1).
- `GAP_CYC`, 4: low time between successive coin pulses, in clocks (≥1).
- `clk`, in, 1: system clock; all logic on the rising edge.
- `rst`, in, 1: reset, asynchronous, active-low.
- `s_state`, in, 4: one-hot state from the vending state machine.
  - 0001 = MONEY_EATER
  - 0010 = DRINK_OUTER
  - 0100 = MONEY_OUTER
  - 1000 = MONEY_OUTER_ALL
- `money_value`, in, MONEY_W: inserted credit, unsigned.
- `drink_out`, out, 1: drink-release actuator pulse.
- `coin10_out`, out, 1: 10-unit coin ejector pulse.
- `coin5_out`, out, 1: 5-unit coin ejector pulse.
- `coin1_out`, out, 1: 1-unit coin ejector pulse.
- `busy`, out, 1: high whenever the FSM is not in IDLE.
- `done`, out, 1: one-clock pulse when the requested action completes.
- `change_total`, out, MONEY_W: value dispensed in the current or last transaction.

## Operation
- **Reset (async, rst=0).**
  - FSM goes to IDLE.
  - All outputs go to 0, including `change_total`.
  - `served` goes to 0001.
  - An in-progress pulse is cut immediately.
- **FSM states:** IDLE, DRINK, SELECT, PULSE, GAP, DONE.
- **Trigger (IDLE only).** A trigger fires when `s_state` ∈ {0010, 0100, 1000} and `s_state` != `served`. On the trigger edge:
  - `served` ← `s_state`.
  - `change_total` ← 0.
  - `served` is reset to 0001 whenever IDLE samples `s_state` = 0001.
  - `s_state` is ignored outside IDLE. A request that is still present on return to IDLE is serviced if it differs from `served`.
  - A non-one-hot or 0000 `s_state` never triggers and leaves `served` unchanged.
- **Action per trigger state:**
  - DRINK_OUTER → DRINK.
  - MONEY_OUTER → SELECT, with `remaining` ← `money_value` − DRINK_VALUE, saturated at 0 if `money_value` < DRINK_VALUE.
  - MONEY_OUTER_ALL → SELECT, with `remaining` ← `money_value`.
  - `money_value` is latched only on the trigger edge; later changes have no effect.
- **DRINK:** `drink_out` = 1 for PULSE_CYC clocks, then → DONE.
- **SELECT:** one clock, all actuators low.
  - `remaining` = 0 → DONE.
  - Otherwise pick the coin: 10 if `remaining` ≥ 10, else 5 if ≥ 5, else 1.
  - Then → PULSE.
- **PULSE:** the selected coin output is high for PULSE_CYC clocks.
  - On entry, `remaining` −= coin and `change_total` += coin.
  - Exactly one actuator output is high at any time.
- **GAP:** all actuators low for GAP_CYC clocks, then → SELECT.
- **DONE:** `done` = 1 for exactly one clock, then → IDLE. `change_total` holds until the next trigger.
- **Arithmetic:** unsigned MONEY_W. Subtraction never wraps; `change_total` never exceeds the latched amount.

## Timing
- All outputs are registered; none has a combinational path from the inputs.
- **Drink action.** With the trigger on edge 0:
  - `drink_out` is high in cycles 1..PULSE_CYC.
  - `done` is high in cycle PULSE_CYC+1.
- **Change action:**
  - SELECT in cycle 1.
  - Each coin costs PULSE_CYC + GAP_CYC + 1 clocks (pulse, gap, next SELECT).
  - DONE follows the final SELECT.
  - Total latency from the trigger to `done` = 2 + n·(PULSE_CYC + GAP_CYC + 1), where n is the coin count.
- **Zero refund:** `done` is high in cycle 2.
- **Busy:** `busy` is high from cycle 1 through the DONE cycle inclusive, and low in IDLE.
- **Back-to-back requests:** the earliest next trigger is the edge after DONE, since IDLE samples `s_state` on its first cycle.

## Test plan
- **Drink release.** Reset, then `s_state` 0001→0010, `money_value` = 30, defaults → `drink_out` high for cycles 1–4, `done` pulse in cycle 5, no coin pulses, `change_total` = 0.
- **Single-coin change.** `s_state` → 0100, `money_value` = 30 → one 4-cycle `coin5_out` pulse in cycles 2–5, `done` in cycle 11, `change_total` = 5.
- **Greedy full refund.** `s_state` → 1000, `money_value` = 17 → pulses in order 10, 5, 1, 1, `done` in cycle 38, `change_total` = 17. `money_value` changed to 99 mid-sequence → no effect.
- **Saturation and zero refund.**
  - `s_state` → 0100 with `money_value` = 20 → no coin pulses, `done` in cycle 2.
  - Separately, `s_state` → 1000 with `money_value` = 0 → same response.
- **Re-trigger and served tracking.**
  - `s_state` held at 0100 after DONE → no second dispense.
  - Then 0001 followed by 0100 → new dispense.
  - `s_state` = 0110 (non-one-hot) → no action.
- **Reset mid-operation.** Assert `rst` = 0 asynchronously during a `coin10_out` pulse → all outputs drop to 0 before the next clock. After release, FSM is IDLE, `change_total` = 0, and the same `s_state` retriggers.
